// File: rtl/encounter_ctrl_if.sv
// -----------------------------------------------------------------------------
// encounter_ctrl_if
// Signal bundle between the overworld/battle sequencing controller and the
// rest of the game pipeline.
//
//   hcount_in / vcount_in  raster position; both zero marks a frame tick
//   step_in                one-cycle pulse per completed tile move
//   in_grass_in            player tile is grass (sampled with step_in)
//   random_in              free-running LFSR value
//   run_in                 battle-finished flag from the battle stage
//   health_battle_in       post-battle player health
//   battle_rst_out         one-cycle reset pulse to the battle stage
//   battle_start_out       high for the whole battle
//   health_out             stored player health fed to the battle stage
//   mode_out               0=OVERWORLD 1=ARM 2=BATTLE 3=GAMEOVER
//   game_over_out          high while in GAMEOVER
//   battles_out            completed battle count (saturating)
//
// Modports: master = pipeline side driving the inputs,
//           slave  = encounter_ctrl.
// -----------------------------------------------------------------------------
interface encounter_ctrl_if;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        step_in;
  logic        in_grass_in;
  logic [7:0]  random_in;
  logic        run_in;
  logic [7:0]  health_battle_in;
  logic        battle_rst_out;
  logic        battle_start_out;
  logic [7:0]  health_out;
  logic [1:0]  mode_out;
  logic        game_over_out;
  logic [7:0]  battles_out;

  modport master (
    output hcount_in, vcount_in, step_in, in_grass_in, random_in,
           run_in, health_battle_in,
    input  battle_rst_out, battle_start_out, health_out, mode_out,
           game_over_out, battles_out
  );

  modport slave (
    input  hcount_in, vcount_in, step_in, in_grass_in, random_in,
           run_in, health_battle_in,
    output battle_rst_out, battle_start_out, health_out, mode_out,
           game_over_out, battles_out
  );
endinterface

// File: rtl/encounter_ctrl.sv
// -----------------------------------------------------------------------------
// encounter_ctrl
// Random-encounter sequencer: watches player steps in grass, arms and runs a
// battle, stores the resulting health, and enters game over when health hits 0.
//
// Ports:
//   clk_in  single system/pixel clock
//   rst_in  synchronous active-high reset
//   bus     encounter_ctrl_if.slave (raster, step, random, battle handshake,
//           health/mode/status outputs)
//
// Optional feature: define ENCOUNTER_AUTO_HEAL_EN to leave GAMEOVER after
// GAMEOVER_FRAMES frame ticks with full health and a fresh cooldown. Without
// it GAMEOVER holds until reset and the frame counter saturates.
// -----------------------------------------------------------------------------
module encounter_ctrl #(
  parameter logic [7:0] ENCOUNTER_THRESH = 8'd40,
  parameter int         COOLDOWN_STEPS   = 4,
  parameter logic [7:0] MAX_HEALTH       = 8'd100,
  parameter int         GAMEOVER_FRAMES  = 120
) (
  input logic             clk_in,
  input logic             rst_in,
  encounter_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_OVERWORLD = 2'd0,
    ST_ARM       = 2'd1,
    ST_BATTLE    = 2'd2,
    ST_GAMEOVER  = 2'd3
  } state_t;

  localparam int         FRAME_W       = (GAMEOVER_FRAMES < 1) ? 1 : $clog2(GAMEOVER_FRAMES + 1);
  localparam logic [7:0] COOLDOWN_INIT = 8'(COOLDOWN_STEPS);
  // Number of leading BATTLE cycles in which run_in is not trusted.
  localparam logic [1:0] RUN_MASK_CYCLES = 2'd2;

  state_t               state_reg, state_next;
  logic [7:0]           health_reg, health_next;
  logic [7:0]           cooldown_reg, cooldown_next;
  logic [7:0]           battles_reg, battles_next;
  logic [FRAME_W-1:0]   frame_cnt_reg, frame_cnt_next;
  logic [1:0]           mask_cnt_reg, mask_cnt_next;
  logic                 battle_rst_reg;
  logic                 battle_start_reg;
  logic                 game_over_reg;

  logic                 frame_tick;
  logic [7:0]           health_clamped;

  assign frame_tick = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);

  // Values above full health can only come from an 8-bit underflow in the
  // battle stage, so they are read as a knockout.
  assign health_clamped = (bus.health_battle_in > MAX_HEALTH) ? 8'd0 : bus.health_battle_in;

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    health_next    = health_reg;
    cooldown_next  = cooldown_reg;
    battles_next   = battles_reg;
    frame_cnt_next = frame_cnt_reg;
    mask_cnt_next  = mask_cnt_reg;

    case (state_reg)
      ST_OVERWORLD: begin
        if (bus.step_in) begin
          // A pending cooldown swallows the step regardless of terrain.
          if (cooldown_reg != 8'd0) begin
            cooldown_next = cooldown_reg - 8'd1;
          end else if (bus.in_grass_in && (bus.random_in < ENCOUNTER_THRESH)) begin
            state_next = ST_ARM;
          end
        end
      end

      ST_ARM: begin
        state_next    = ST_BATTLE;
        mask_cnt_next = 2'd0;
      end

      ST_BATTLE: begin
        if (mask_cnt_reg != RUN_MASK_CYCLES) begin
          mask_cnt_next = mask_cnt_reg + 2'd1;
        end else if (bus.run_in) begin
          health_next  = health_clamped;
          battles_next = (battles_reg != 8'hFF) ? battles_reg + 8'd1 : battles_reg;
          if (health_clamped == 8'd0) begin
            state_next     = ST_GAMEOVER;
            frame_cnt_next = '0;
          end else begin
            state_next    = ST_OVERWORLD;
            cooldown_next = COOLDOWN_INIT;
          end
        end
      end

      ST_GAMEOVER: begin
        if (frame_tick) begin
`ifdef ENCOUNTER_AUTO_HEAL_EN
          if (frame_cnt_reg == FRAME_W'(GAMEOVER_FRAMES - 1)) begin
            state_next     = ST_OVERWORLD;
            health_next    = MAX_HEALTH;
            cooldown_next  = COOLDOWN_INIT;
            frame_cnt_next = '0;
          end else begin
            frame_cnt_next = frame_cnt_reg + 1'b1;
          end
`else
          if (frame_cnt_reg != {FRAME_W{1'b1}}) begin
            frame_cnt_next = frame_cnt_reg + 1'b1;
          end
`endif
        end
      end

      default: state_next = ST_OVERWORLD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs. Status outputs are decoded from the next
  // state so they line up cycle-for-cycle with mode_out.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg        <= ST_OVERWORLD;
      health_reg       <= MAX_HEALTH;
      cooldown_reg     <= 8'd0;
      battles_reg      <= 8'd0;
      frame_cnt_reg    <= '0;
      mask_cnt_reg     <= 2'd0;
      battle_rst_reg   <= 1'b1;
      battle_start_reg <= 1'b0;
      game_over_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      health_reg       <= health_next;
      cooldown_reg     <= cooldown_next;
      battles_reg      <= battles_next;
      frame_cnt_reg    <= frame_cnt_next;
      mask_cnt_reg     <= mask_cnt_next;
      battle_rst_reg   <= (state_next == ST_ARM);
      battle_start_reg <= (state_next == ST_BATTLE);
      game_over_reg    <= (state_next == ST_GAMEOVER);
    end
  end

  assign bus.battle_rst_out   = battle_rst_reg;
  assign bus.battle_start_out = battle_start_reg;
  assign bus.health_out       = health_reg;
  assign bus.mode_out         = state_reg;
  assign bus.game_over_out    = game_over_reg;
  assign bus.battles_out      = battles_reg;

endmodule

// File: tb/tb_encounter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_encounter_ctrl
// Directed bench for encounter_ctrl: encounter trigger, run masking, health
// latch, cooldown, game over and mid-battle reset. Inputs change 1 ns after
// the rising edge; outputs are checked at the same point, after the edge that
// consumed the inputs.
// -----------------------------------------------------------------------------
module tb_encounter_ctrl;

  logic clk_in = 1'b0;
  logic rst_in;

  encounter_ctrl_if bus_if ();

  encounter_ctrl dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus_if.slave)
  );

  always #5 clk_in = ~clk_in;

  int compare_cnt  = 0;
  int mismatch_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compare_cnt++;
    if (got !== exp) begin
      mismatch_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_step(input logic grass, input logic [7:0] rnd);
    bus_if.step_in     = 1'b1;
    bus_if.in_grass_in = grass;
    bus_if.random_in   = rnd;
    tick();
    bus_if.step_in     = 1'b0;
  endtask

  task automatic frame_pulse();
    bus_if.hcount_in = 11'd0;
    bus_if.vcount_in = 10'd0;
    tick();
    bus_if.hcount_in = 11'd5;
    bus_if.vcount_in = 10'd3;
    tick();
  endtask

  initial begin
    rst_in                  = 1'b1;
    bus_if.hcount_in        = 11'd5;
    bus_if.vcount_in        = 10'd3;
    bus_if.step_in          = 1'b0;
    bus_if.in_grass_in      = 1'b0;
    bus_if.random_in        = 8'd200;
    bus_if.run_in           = 1'b0;
    bus_if.health_battle_in = 8'd0;

    // Reset state
    tick();
    tick();
    check("rst_mode",       32'(bus_if.mode_out), 32'd0);
    check("rst_health",     32'(bus_if.health_out), 32'd100);
    check("rst_battles",    32'(bus_if.battles_out), 32'd0);
    check("rst_battle_rst", 32'(bus_if.battle_rst_out), 32'd1);
    check("rst_start",      32'(bus_if.battle_start_out), 32'd0);
    check("rst_gameover",   32'(bus_if.game_over_out), 32'd0);
    rst_in = 1'b0;
    tick();
    check("post_rst_battle_rst", 32'(bus_if.battle_rst_out), 32'd0);

    // No trigger: random at threshold, and non-grass tile
    do_step(1'b1, 8'd40);
    check("rand40_mode", 32'(bus_if.mode_out), 32'd0);
    do_step(1'b0, 8'd0);
    check("nograss_mode", 32'(bus_if.mode_out), 32'd0);

    // Trigger -> ARM for one cycle -> BATTLE
    do_step(1'b1, 8'd10);
    check("arm_mode",       32'(bus_if.mode_out), 32'd1);
    check("arm_battle_rst", 32'(bus_if.battle_rst_out), 32'd1);
    check("arm_start",      32'(bus_if.battle_start_out), 32'd0);
    tick();
    check("battle_mode",       32'(bus_if.mode_out), 32'd2);
    check("battle_battle_rst", 32'(bus_if.battle_rst_out), 32'd0);
    check("battle_start",      32'(bus_if.battle_start_out), 32'd1);
    check("battle_health",     32'(bus_if.health_out), 32'd100);

    // Run on battle cycle 1 is masked; cycle 3 run (with step) is accepted
    bus_if.run_in           = 1'b1;
    bus_if.health_battle_in = 8'd70;
    tick();
    bus_if.run_in = 1'b0;
    check("mask_c1_mode", 32'(bus_if.mode_out), 32'd2);
    tick();
    check("mask_c2_mode", 32'(bus_if.mode_out), 32'd2);
    bus_if.run_in      = 1'b1;
    bus_if.step_in     = 1'b1;
    bus_if.in_grass_in = 1'b1;
    bus_if.random_in   = 8'd0;
    tick();
    bus_if.run_in  = 1'b0;
    bus_if.step_in = 1'b0;
    check("win_mode",    32'(bus_if.mode_out), 32'd0);
    check("win_health",  32'(bus_if.health_out), 32'd70);
    check("win_battles", 32'(bus_if.battles_out), 32'd1);
    check("win_start",   32'(bus_if.battle_start_out), 32'd0);

    // Cooldown: four grass steps swallowed, fifth triggers
    for (int i = 0; i < 4; i++) begin
      do_step(1'b1, 8'd0);
      check($sformatf("cool_step%0d_mode", i + 1), 32'(bus_if.mode_out), 32'd0);
      tick();
    end
    do_step(1'b1, 8'd0);
    check("cool_step5_mode", 32'(bus_if.mode_out), 32'd1);
    tick();
    check("b2_mode", 32'(bus_if.mode_out), 32'd2);

    // Wrapped health -> GAMEOVER (run held through the mask)
    bus_if.run_in           = 1'b1;
    bus_if.health_battle_in = 8'd252;
    tick();
    tick();
    check("b2_masked_mode", 32'(bus_if.mode_out), 32'd2);
    tick();
    bus_if.run_in = 1'b0;
    check("ko_mode",     32'(bus_if.mode_out), 32'd3);
    check("ko_gameover", 32'(bus_if.game_over_out), 32'd1);
    check("ko_health",   32'(bus_if.health_out), 32'd0);
    check("ko_battles",  32'(bus_if.battles_out), 32'd2);
    check("ko_start",    32'(bus_if.battle_start_out), 32'd0);

    // Steps are ignored in GAMEOVER
    do_step(1'b1, 8'd0);
    check("go_step_mode", 32'(bus_if.mode_out), 32'd3);

`ifdef ENCOUNTER_AUTO_HEAL_EN
    for (int i = 0; i < 119; i++) frame_pulse();
    check("heal_119_mode", 32'(bus_if.mode_out), 32'd3);
    frame_pulse();
    check("heal_mode",     32'(bus_if.mode_out), 32'd0);
    check("heal_health",   32'(bus_if.health_out), 32'd100);
    check("heal_gameover", 32'(bus_if.game_over_out), 32'd0);
`else
    for (int i = 0; i < 200; i++) frame_pulse();
    check("hold_mode",     32'(bus_if.mode_out), 32'd3);
    check("hold_gameover", 32'(bus_if.game_over_out), 32'd1);
    check("hold_health",   32'(bus_if.health_out), 32'd0);
`endif

    // Reset mid-battle
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    tick();
    do_step(1'b1, 8'd10);
    tick();
    check("rb_mode", 32'(bus_if.mode_out), 32'd2);
    tick();
    rst_in = 1'b1;
    bus_if.run_in           = 1'b1;
    bus_if.health_battle_in = 8'd30;
    tick();
    check("midrst_mode",       32'(bus_if.mode_out), 32'd0);
    check("midrst_start",      32'(bus_if.battle_start_out), 32'd0);
    check("midrst_health",     32'(bus_if.health_out), 32'd100);
    check("midrst_battles",    32'(bus_if.battles_out), 32'd0);
    check("midrst_battle_rst", 32'(bus_if.battle_rst_out), 32'd1);
    rst_in        = 1'b0;
    bus_if.run_in = 1'b0;
    tick();
    check("midrst_release_battle_rst", 32'(bus_if.battle_rst_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule
